output_argmax: RTL and testbench
================================

# output_argmax

Sequential readout stage at the output end of the digit-classifier network. Accepts one frame of final-layer axon values (signed fixed-point class scores), scans them one per cycle, and returns the winning class index and its score over a valid/ready handshake. It sits between `neural_net`'s last layer and the display/UART reporting logic on the Basys3.

## Interface
- `NUM_CLASSES`, default 10: number of class scores per frame; legal range ≥ 2.
- `DATA_W`, default 32: score width, two's-complement signed.
- `IDX_W`, default `$clog2(NUM_CLASSES)`: class index width.

Ports (clock and reset first):
- `clk` input 1: single clock.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: a score frame is presented.
- `in_ready` output 1: block can accept a frame.
- `scores` input `[DATA_W-1:0]` × `NUM_CLASSES`: unpacked array of class scores, sampled only on input handshake.
- `out_valid` output 1: a result is held.
- `out_ready` input 1: downstream accepts the result.
- `class_idx` output `IDX_W`: winning class index.
- `max_score` output `DATA_W`: winning score.

## Operation
- The FSM has three states: IDLE, SCAN and DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid && in_ready`, all scores are registered into a frame buffer; best←`scores[0]`, idx←0, counter i←1; go to SCAN.
- **SCAN**
  - Each cycle compares `buf[i]` with best using a signed comparison.
  - If `buf[i]` > best (strict), best←`buf[i]` and idx←i.
  - i increments each cycle. After processing i = `NUM_CLASSES-1`, go to DONE.
- **DONE**
  - `out_valid`=1; `class_idx`/`max_score` are stable.
  - On `out_ready`, go to IDLE.
- Ties keep the lowest index, because the comparison is strict.
- `in_ready`=0 in SCAN and DONE. Frames are never dropped or overwritten, and `scores` is ignored outside the IDLE handshake.
- The counter never wraps past `NUM_CLASSES-1`.
- Outputs hold their last result after returning to IDLE until the next frame overwrites them at the end of its scan. `out_valid` is the only qualifier.

## Timing
- Reset values:
  - state=IDLE, `out_valid`=0, `class_idx`=0, `max_score`=0.
  - `in_ready`=0 while `rst` is high, then 1 in the first cycle after release.
- Latency: an input handshake in cycle 0 raises `out_valid` in cycle `NUM_CLASSES` (cycle 10 for the default).
- Throughput with `out_ready` tied high: one frame per `NUM_CLASSES+1` cycles.
- `out_ready` high in DONE together with `in_valid`: the result is consumed that cycle. The new frame is accepted in the following IDLE cycle, not the same cycle.
- `out_ready` is ignored outside DONE.
- `rst` in any state (mid-scan included) aborts the scan and restores all reset values on the next edge.

## Configuration
- Macro: `OUTPUT_ARGMAX_RUNNERUP_EN`.
- **Defined:**
  - Adds output ports `second_idx` (`IDX_W`) and `margin` (`DATA_W`, unsigned).
  - On capture: second←most-negative `DATA_W` value, `second_idx`←0.
  - In SCAN:
    - If `buf[i]` > best, second←old best and `second_idx`←old idx, then best is updated.
    - Else if `buf[i]` > second, second←`buf[i]` and `second_idx`←i.
  - `margin` = best − second, computed with a `DATA_W+1`-bit intermediate and saturated to `2^DATA_W−1`.
  - `margin` is registered and valid with `out_valid`. Both new ports reset to 0.
- **Undefined:** these ports and their logic are absent. Core behaviour and latency are unchanged.

## Structure
- Shared package `nn_pkg` holds:
  - the `score_t` typedef (signed `[DATA_W-1:0]`);
  - the state enum `argmax_state_e` {IDLE, SCAN, DONE};
  - the default constant `NN_NUM_CLASSES`=10.
- One sub-module, `argmax_update`: purely combinational. It takes (candidate, index, best, best_idx[, second, second_idx]) and produces the next best/runner-up, so the tie rule is defined in one place.

## Test plan
- **Unique maximum.** Scores {5,−3,7,100,2,0,−1,9,8,1} → `out_valid` in cycle 10; `class_idx`=3, `max_score`=100.
- **All negative, with a tie.** Scores {−50,−7,−7,−90,…(all −100)} → `class_idx`=1, `max_score`=−7 (signed compare, lowest index wins).
- **Backpressure.** Hold `out_ready`=0 for 20 cycles after DONE.
  - Outputs stay stable and `in_ready` stays 0.
  - A second frame presented meanwhile is accepted only on the cycle after the `out_ready` handshake.
- **Reset mid-scan.** Assert `rst` at cycle 4 of SCAN → next cycle `out_valid`=0, outputs 0, `in_ready`=1 after release; a fresh frame gives a correct result.
- **Streaming.** With `out_ready` and `in_valid` held high, 3 frames produce results spaced 11 cycles apart with correct indices.
- **Runner-up (`OUTPUT_ARGMAX_RUNNERUP_EN`).**
  - Scores {10,40,30,…0} → `class_idx`=1, `second_idx`=2, `margin`=10.
  - Scores {max positive, most negative, …} → `margin` saturates to 0xFFFFFFFF.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared definitions for the digit-classifier network datapath.
// Holds the default class count, the class-score type and the state
// encoding of the output argmax readout stage.
package nn_pkg;

   localparam int NN_NUM_CLASSES = 10;
   localparam int NN_DATA_W      = 32;

   typedef logic signed [NN_DATA_W-1:0] score_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } argmax_state_e;

endpackage

// File: rtl/argmax_update.sv
// Combinational running-maximum update step for output_argmax.
// Given one candidate score and its index, plus the current best (and,
// with OUTPUT_ARGMAX_RUNNERUP_EN defined, the current runner-up), produces
// the next best/runner-up. The strict comparisons here are the single
// place that defines the tie rule: on equal scores the lower index wins.
//
// Ports:
//   cand, cand_idx           candidate score (signed) and its class index
//   best, best_idx           current best score and index
//   second, second_idx       current runner-up (OUTPUT_ARGMAX_RUNNERUP_EN only)
//   nbest, nbest_idx         updated best
//   nsecond, nsecond_idx     updated runner-up (OUTPUT_ARGMAX_RUNNERUP_EN only)
module argmax_update
   import nn_pkg::*;
#(
   parameter int DATA_W = NN_DATA_W,
   parameter int IDX_W  = 4
) (
   input  logic signed [DATA_W-1:0] cand,
   input  logic        [IDX_W-1:0]  cand_idx,
   input  logic signed [DATA_W-1:0] best,
   input  logic        [IDX_W-1:0]  best_idx,
`ifdef OUTPUT_ARGMAX_RUNNERUP_EN
   input  logic signed [DATA_W-1:0] second,
   input  logic        [IDX_W-1:0]  second_idx,
   output logic signed [DATA_W-1:0] nsecond,
   output logic        [IDX_W-1:0]  nsecond_idx,
`endif
   output logic signed [DATA_W-1:0] nbest,
   output logic        [IDX_W-1:0]  nbest_idx
);

   always_comb begin
      nbest     = best;
      nbest_idx = best_idx;
`ifdef OUTPUT_ARGMAX_RUNNERUP_EN
      nsecond     = second;
      nsecond_idx = second_idx;
`endif
      if (cand > best) begin
         nbest     = cand;
         nbest_idx = cand_idx;
`ifdef OUTPUT_ARGMAX_RUNNERUP_EN
         // the displaced best becomes the runner-up
         nsecond     = best;
         nsecond_idx = best_idx;
`endif
      end
`ifdef OUTPUT_ARGMAX_RUNNERUP_EN
      else if (cand > second) begin
         nsecond     = cand;
         nsecond_idx = cand_idx;
      end
`endif
   end

endmodule

// File: rtl/output_argmax.sv
// Output readout stage of the digit classifier: captures one frame of
// final-layer class scores, scans them one per cycle and presents the
// winning class index and score over a valid/ready handshake.
//
// Optional feature macro: OUTPUT_ARGMAX_RUNNERUP_EN adds the runner-up
// index and the (saturated, unsigned) winner-minus-runner-up margin.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   frame handshake; scores sampled on handshake only
//   scores[NUM_CLASSES]   signed class scores
//   out_valid / out_ready result handshake
//   class_idx, max_score  winning class and its score
//   second_idx, margin    runner-up index and margin (macro only)
//
// state | meaning
// IDLE  | waiting for a frame, in_ready high
// SCAN  | comparing buffered score i against the running best
// DONE  | result held with out_valid high until out_ready
module output_argmax
   import nn_pkg::*;
#(
   parameter int NUM_CLASSES = NN_NUM_CLASSES,
   parameter int DATA_W      = NN_DATA_W,
   parameter int IDX_W       = $clog2(NUM_CLASSES)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] scores [NUM_CLASSES],
   output logic              out_valid,
   input  logic              out_ready,
   output logic [IDX_W-1:0]  class_idx,
`ifdef OUTPUT_ARGMAX_RUNNERUP_EN
   output logic [IDX_W-1:0]  second_idx,
   output logic [DATA_W-1:0] margin,
`endif
   output logic [DATA_W-1:0] max_score
);

   localparam logic [1:0] ST_IDLE = IDLE;
   localparam logic [1:0] ST_SCAN = SCAN;
   localparam logic [1:0] ST_DONE = DONE;

   localparam logic [IDX_W-1:0] LAST_I = IDX_W'(NUM_CLASSES - 1);

   logic [1:0]               state;
   logic [DATA_W-1:0]        fbuf [NUM_CLASSES];
   logic [IDX_W-1:0]         i;
   logic signed [DATA_W-1:0] best;
   logic [IDX_W-1:0]         best_idx;
   logic signed [DATA_W-1:0] cand;
   logic signed [DATA_W-1:0] nbest;
   logic [IDX_W-1:0]         nbest_idx;
   logic                     take;

   assign in_ready  = !rst && (state == ST_IDLE);
   assign out_valid = (state == ST_DONE);
   assign take      = (state == ST_IDLE) && in_valid && !rst;
   assign cand      = fbuf[i];

`ifdef OUTPUT_ARGMAX_RUNNERUP_EN
   localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

   logic signed [DATA_W-1:0] second;
   logic [IDX_W-1:0]         second_i;
   logic signed [DATA_W-1:0] nsecond;
   logic [IDX_W-1:0]         nsecond_idx;
   logic [DATA_W:0]          diff;
   logic [DATA_W-1:0]        margin_nxt;

   // sign-extended difference; the top bit flags a result that does not
   // fit DATA_W unsigned bits
   assign diff       = {nbest[DATA_W-1], nbest} - {nsecond[DATA_W-1], nsecond};
   assign margin_nxt = diff[DATA_W] ? {DATA_W{1'b1}} : diff[DATA_W-1:0];
`endif

   argmax_update #(
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W)
   ) u_update (
      .cand        (cand),
      .cand_idx    (i),
      .best        (best),
      .best_idx    (best_idx),
`ifdef OUTPUT_ARGMAX_RUNNERUP_EN
      .second      (second),
      .second_idx  (second_i),
      .nsecond     (nsecond),
      .nsecond_idx (nsecond_idx),
`endif
      .nbest       (nbest),
      .nbest_idx   (nbest_idx)
   );

   // frame buffer is pure data, loaded only on the input handshake
   always_ff @(posedge clk) begin
      if (take) begin
         fbuf <= scores;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         i         <= '0;
         best      <= '0;
         best_idx  <= '0;
         class_idx <= '0;
         max_score <= '0;
`ifdef OUTPUT_ARGMAX_RUNNERUP_EN
         second     <= '0;
         second_i   <= '0;
         second_idx <= '0;
         margin     <= '0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  best     <= scores[0];
                  best_idx <= '0;
                  i        <= IDX_W'(1);
`ifdef OUTPUT_ARGMAX_RUNNERUP_EN
                  second   <= MOST_NEG;
                  second_i <= '0;
`endif
                  state    <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               best     <= nbest;
               best_idx <= nbest_idx;
`ifdef OUTPUT_ARGMAX_RUNNERUP_EN
               second   <= nsecond;
               second_i <= nsecond_idx;
`endif
               if (i == LAST_I) begin
                  class_idx <= nbest_idx;
                  max_score <= nbest;
`ifdef OUTPUT_ARGMAX_RUNNERUP_EN
                  second_idx <= nsecond_idx;
                  margin     <= margin_nxt;
`endif
                  state     <= ST_DONE;
               end else begin
                  i <= i + IDX_W'(1);
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_output_argmax.sv
module tb_output_argmax;

   localparam int NC = 10;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] sc_in [NC];
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  class_idx;
   logic [31:0] max_score;
`ifdef OUTPUT_ARGMAX_RUNNERUP_EN
   logic [3:0]  second_idx;
   logic [31:0] margin;
`endif

   int total = 0;
   int bad   = 0;

   output_argmax dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .scores     (sc_in),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .class_idx  (class_idx),
`ifdef OUTPUT_ARGMAX_RUNNERUP_EN
      .second_idx (second_idx),
      .margin     (margin),
`endif
      .max_score  (max_score)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: winner is the lowest-indexed maximum (signed). Runner-up is
   // the lowest-indexed maximum of the remaining classes, except that a
   // runner-up equal to the most-negative value never displaces the initial
   // runner-up (index 0) when the winner sits at index 0.
   function automatic void model(input logic [31:0] f [NC], output int w,
                                 output int s, output logic [31:0] m);
      longint d;
      logic [31:0] sv;
      w = 0;
      for (int j = 1; j < NC; j++)
         if ($signed(f[j]) > $signed(f[w])) w = j;
      s = -1;
      for (int j = 0; j < NC; j++)
         if (j != w && (s < 0 || $signed(f[j]) > $signed(f[s]))) s = j;
      sv = f[s];
      if (w == 0 && sv == 32'h8000_0000) s = 0;
      d = longint'($signed(f[w])) - longint'($signed(sv));
      m = (d > 64'sh0_FFFF_FFFF) ? 32'hFFFF_FFFF : d[31:0];
   endfunction

   task automatic check_result(input string tag, input logic [31:0] f [NC]);
      int w, s;
      logic [31:0] m;
      model(f, w, s, m);
      chk({tag, "_idx"}, {60'd0, class_idx}, 64'(w));
      chk({tag, "_score"}, {32'd0, max_score}, {32'd0, f[w]});
`ifdef OUTPUT_ARGMAX_RUNNERUP_EN
      chk({tag, "_second_idx"}, {60'd0, second_idx}, 64'(s));
      chk({tag, "_margin"}, {32'd0, margin}, {32'd0, m});
`endif
   endtask

   // waits for in_ready, then presents the frame for exactly one cycle;
   // returns at the sampling point of the first cycle after the handshake
   task automatic send(input logic [31:0] f [NC]);
      int n = 0;
      while (!in_ready && n < 100) begin
         step();
         n++;
      end
      if (n >= 100) chk("in_ready_timeout", 64'd0, 64'd1);
      sc_in    = f;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   // cycle number (handshake = cycle 0) in which out_valid is first seen
   task automatic wait_result(output int lat);
      lat = 1;
      while (!out_valid && lat < 100) begin
         step();
         lat++;
      end
   endtask

   task automatic consume();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   function automatic void from_int(input int v [NC], output logic [31:0] f [NC]);
      for (int j = 0; j < NC; j++) f[j] = v[j];
   endfunction

   initial begin
      logic [31:0] fa [NC];
      logic [31:0] fb [NC];
      logic [31:0] sf [3][NC];
      int          vi [NC];
      int          lat, w, s, sent, got, prev, cyc;
      logic [31:0] m;
      logic [3:0]  held_idx;

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      for (int j = 0; j < NC; j++) sc_in[j] = '0;

      step();
      step();
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_class_idx", {60'd0, class_idx}, 64'd0);
      chk("rst_max_score", {32'd0, max_score}, 64'd0);
      chk("rst_in_ready_held", {63'd0, in_ready}, 64'd0);
`ifdef OUTPUT_ARGMAX_RUNNERUP_EN
      chk("rst_second_idx", {60'd0, second_idx}, 64'd0);
      chk("rst_margin", {32'd0, margin}, 64'd0);
`endif
      rst = 1'b0;
      #1;
      chk("rst_in_ready_release", {63'd0, in_ready}, 64'd1);

      // unique maximum
      vi = '{5, -3, 7, 100, 2, 0, -1, 9, 8, 1};
      from_int(vi, fa);
      send(fa);
      wait_result(lat);
      chk("uniq_latency", 64'(lat), 64'd10);
      chk("uniq_idx_const", {60'd0, class_idx}, 64'd3);
      chk("uniq_score_const", {32'd0, max_score}, 64'd100);
      check_result("uniq", fa);
      consume();
      chk("uniq_out_valid_drop", {63'd0, out_valid}, 64'd0);
      chk("uniq_in_ready_back", {63'd0, in_ready}, 64'd1);
      chk("uniq_hold_idx", {60'd0, class_idx}, 64'd3);

      // all negative with a tie at the maximum
      vi = '{-50, -7, -7, -90, -100, -100, -100, -100, -100, -100};
      from_int(vi, fb);
      send(fb);
      wait_result(lat);
      chk("tie_latency", 64'(lat), 64'd10);
      chk("tie_idx_const", {60'd0, class_idx}, 64'd1);
      chk("tie_score_const", {32'd0, max_score}, {32'd0, 32'hFFFF_FFF9});
      check_result("tie", fb);
      consume();

      // backpressure: result held, second frame waits for the handshake
      send(fa);
      wait_result(lat);
      chk("bp_latency", 64'(lat), 64'd10);
      sc_in    = fb;
      in_valid = 1'b1;
      for (int k = 0; k < 20; k++) begin
         chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
         chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
         chk("bp_idx_stable", {60'd0, class_idx}, 64'd3);
         chk("bp_score_stable", {32'd0, max_score}, 64'd100);
         step();
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("bp_after_in_ready", {63'd0, in_ready}, 64'd1);
      chk("bp_after_out_valid", {63'd0, out_valid}, 64'd0);
      chk("bp_after_hold", {60'd0, class_idx}, 64'd3);
      step();
      in_valid = 1'b0;
      chk("bp_accepted", {63'd0, in_ready}, 64'd0);
      wait_result(lat);
      chk("bp2_latency", 64'(lat), 64'd10);
      check_result("bp2", fb);
      consume();

      // reset in the fourth SCAN cycle
      for (int j = 0; j < NC; j++) fb[j] = $urandom;
      send(fb);
      step();
      step();
      step();
      rst = 1'b1;
      step();
      chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("mid_rst_idx", {60'd0, class_idx}, 64'd0);
      chk("mid_rst_score", {32'd0, max_score}, 64'd0);
      rst = 1'b0;
      #1;
      chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
      for (int j = 0; j < NC; j++) fa[j] = $urandom;
      send(fa);
      wait_result(lat);
      chk("mid_rst_latency", 64'(lat), 64'd10);
      check_result("mid_rst_fresh", fa);
      consume();

      // streaming with both valid and ready held high
      for (int k = 0; k < 3; k++)
         for (int j = 0; j < NC; j++) sf[k][j] = 32'($urandom_range(0, 40)) - 32'd20;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      sent = 0;
      got  = 0;
      prev = 0;
      cyc  = 0;
      while (got < 3 && cyc < 100) begin
         if (out_valid) begin
            fa = sf[got];
            check_result("stream", fa);
            if (got > 0) chk("stream_gap", 64'(cyc - prev), 64'd11);
            prev = cyc;
            got++;
         end
         if (in_ready) begin
            if (sent < 3) begin
               sc_in = sf[sent];
               sent++;
            end else begin
               in_valid = 1'b0;
            end
         end
         step();
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      chk("stream_count", 64'(got), 64'd3);
      step();

`ifdef OUTPUT_ARGMAX_RUNNERUP_EN
      vi = '{10, 40, 30, 0, 0, 0, 0, 0, 0, 0};
      from_int(vi, fa);
      send(fa);
      wait_result(lat);
      chk("ru_idx", {60'd0, class_idx}, 64'd1);
      chk("ru_second_idx", {60'd0, second_idx}, 64'd2);
      chk("ru_margin", {32'd0, margin}, 64'd10);
      consume();
      for (int j = 0; j < NC; j++) fa[j] = 32'h8000_0000;
      fa[0] = 32'h7FFF_FFFF;
      send(fa);
      wait_result(lat);
      chk("ru_sat_margin", {32'd0, margin}, {32'd0, 32'hFFFF_FFFF});
      chk("ru_sat_second_idx", {60'd0, second_idx}, 64'd0);
      consume();
`endif

      // randomized frames with mixed value ranges and random drain delay
      for (int t = 0; t < 25; t++) begin
         for (int j = 0; j < NC; j++)
            fa[j] = (t % 2 == 0) ? $urandom : 32'($urandom_range(0, 6)) - 32'd3;
         send(fa);
         wait_result(lat);
         chk("rand_latency", 64'(lat), 64'd10);
         check_result("rand", fa);
         model(fa, w, s, m);
         held_idx = 4'(w);
         for (int d = $urandom_range(0, 3); d > 0; d--) step();
         chk("rand_held", {60'd0, class_idx}, {60'd0, held_idx});
         consume();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
